// File: rtl/cycloneii_dly_cal_pkg.sv
// Shared state encoding and delay-code constants for the Cyclone II delay-calibration sequencer.
// The TRACK state and tracking sub-steps exist only when CYCLONEII_DLY_CAL_SEQ_TRACK_EN is defined.
package cycloneii_dly_cal_pkg;

    localparam int                    DLY_CODE_W   = 6;
    localparam logic [DLY_CODE_W-1:0] DLY_CODE_MAX = 6'd63;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_EVAL   = 3'd3,
        ST_DONE   = 3'd4,
        ST_FAIL   = 3'd5
`ifdef CYCLONEII_DLY_CAL_SEQ_TRACK_EN
        , ST_TRACK = 3'd6
`endif
    } state_e;

`ifdef CYCLONEII_DLY_CAL_SEQ_TRACK_EN
    typedef enum logic [1:0] {
        TRK_CUR    = 2'd0,
        TRK_SETTLE = 2'd1,
        TRK_LOW    = 2'd2
    } trk_step_e;
`endif

    function automatic logic [DLY_CODE_W-1:0] code_inc(input logic [DLY_CODE_W-1:0] c);
        return (c == DLY_CODE_MAX) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/cycloneii_dly_cal_phase_sampler.sv
// Synchronizes the atom clocks, counts votes per synchronized delayed-clock rise and flags a dead clock.
// Vote/timeout are combinational in the deciding cycle; counters clear whenever enable_i is low.
module cycloneii_dly_cal_phase_sampler #(
    parameter int NUM_SAMPLES    = 15,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic devclrn,
    input  logic enable_i,
    input  logic calibratedata_i,
    input  logic dlyclk_i,
    output logic vote_vld_o,
    output logic vote_o,
    output logic timeout_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    dat_sync_q;
    logic [1:0]    dly_sync_q;
    logic          dly_prev_q;
    logic [7:0]    evt_cnt_q, evt_cnt_d;
    logic [7:0]    ones_cnt_q, ones_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          evt;
    logic [7:0]    ones_next;

    // Equal-depth synchronizers keep data aligned with the edge it was launched on.
    assign evt       = dly_sync_q[1] & ~dly_prev_q;
    assign ones_next = ones_cnt_q + {7'd0, dat_sync_q[1]};

    always_comb begin
        evt_cnt_d  = evt_cnt_q;
        ones_cnt_d = ones_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        vote_vld_o = 1'b0;
        vote_o     = 1'b0;
        timeout_o  = 1'b0;
        if (!enable_i) begin
            evt_cnt_d  = '0;
            ones_cnt_d = '0;
            tmo_cnt_d  = '0;
        end else if (evt) begin
            tmo_cnt_d = '0;
            if (evt_cnt_q == 8'(NUM_SAMPLES - 1)) begin
                vote_vld_o = 1'b1;
                vote_o     = (ones_next > 8'(NUM_SAMPLES / 2));
                evt_cnt_d  = '0;
                ones_cnt_d = '0;
            end else begin
                evt_cnt_d  = evt_cnt_q + 8'd1;
                ones_cnt_d = ones_next;
            end
        end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout_o = 1'b1;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge devclrn) begin
        if (!devclrn) begin
            dat_sync_q <= '0;
            dly_sync_q <= '0;
            dly_prev_q <= 1'b0;
            evt_cnt_q  <= '0;
            ones_cnt_q <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            dat_sync_q <= {dat_sync_q[0], calibratedata_i};
            dly_sync_q <= {dly_sync_q[0], dlyclk_i};
            dly_prev_q <= dly_sync_q[1];
            evt_cnt_q  <= evt_cnt_d;
            ones_cnt_q <= ones_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

endmodule

// File: rtl/cycloneii_dly_cal_sequencer.sv
// Sweeps the atom delay code until the voted phase flips; status flags are registered with the state.
// No backpressure: start is ignored while busy. CYCLONEII_DLY_CAL_SEQ_TRACK_EN adds periodic tracking in DONE.
module cycloneii_dly_cal_sequencer
    import cycloneii_dly_cal_pkg::*;
#(
    parameter int    NUM_SAMPLES    = 15,
    parameter int    SETTLE_CYCLES  = 32,
    parameter int    TIMEOUT_CYCLES = 4096,
    parameter int    TRACK_INTERVAL = 65536,
    parameter string lpm_type       = "cycloneii_dly_cal_sequencer"
) (
    input  logic                  clk,
    input  logic                  devclrn,
    input  logic                  start,
    input  logic                  calibratedata,
    input  logic                  pllcalibrateclkdelayedout,
    output logic [DLY_CODE_W-1:0] delayctrlout,
    output logic                  disablecalibration,
    output logic                  busy,
    output logic                  done,
    output logic                  locked,
    output logic                  error
);

    if (NUM_SAMPLES < 1 || NUM_SAMPLES > 255 || (NUM_SAMPLES % 2) == 0 || SETTLE_CYCLES < 1 ||
        TIMEOUT_CYCLES < 1 || TRACK_INTERVAL < 1 || lpm_type == "") begin : g_bad_param
        $error("cycloneii_dly_cal_sequencer: illegal parameter value");
    end

    localparam int SCW = $clog2(SETTLE_CYCLES + 1);

    state_e                state_q, state_d;
    logic [DLY_CODE_W-1:0] code_q, code_d;
    logic                  ref_q, ref_d;
    logic                  vote_q, vote_d;
    logic [SCW-1:0]        settle_q, settle_d;
    logic                  dis_q, dis_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  locked_q, locked_d;
    logic                  error_q, error_d;
    logic                  smp_en, smp_vld, smp_vote, smp_tmo;
    logic                  launch, go_fail, settle_last;

`ifdef CYCLONEII_DLY_CAL_SEQ_TRACK_EN
    localparam int   TCW      = $clog2(TRACK_INTERVAL + 1);
    localparam logic LOCK_DIS = 1'b0;
    trk_step_e             trk_step_q, trk_step_d;
    logic [TCW-1:0]        trk_cnt_q, trk_cnt_d;
    logic [DLY_CODE_W-1:0] trk_home_q, trk_home_d;

    assign smp_en = (state_q == ST_SAMPLE) || (state_q == ST_TRACK && trk_step_q != TRK_SETTLE);
`else
    localparam logic LOCK_DIS = 1'b1;

    assign smp_en = (state_q == ST_SAMPLE);
`endif

    assign settle_last = (settle_q == SCW'(SETTLE_CYCLES - 1));

    cycloneii_dly_cal_phase_sampler #(
        .NUM_SAMPLES   (NUM_SAMPLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_sampler (
        .clk            (clk),
        .devclrn        (devclrn),
        .enable_i       (smp_en),
        .calibratedata_i(calibratedata),
        .dlyclk_i       (pllcalibrateclkdelayedout),
        .vote_vld_o     (smp_vld),
        .vote_o         (smp_vote),
        .timeout_o      (smp_tmo)
    );

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        ref_d    = ref_q;
        vote_d   = vote_q;
        settle_d = settle_q;
        dis_d    = dis_q;
        busy_d   = busy_q;
        done_d   = done_q;
        locked_d = locked_q;
        error_d  = error_q;
        launch   = 1'b0;
        go_fail  = 1'b0;
`ifdef CYCLONEII_DLY_CAL_SEQ_TRACK_EN
        trk_step_d = trk_step_q;
        trk_cnt_d  = '0;
        trk_home_d = trk_home_q;
`endif
        case (state_q)
            ST_IDLE, ST_FAIL: launch = start;
            ST_SETTLE: begin
                if (settle_last) begin
                    settle_d = '0;
                    state_d  = ST_SAMPLE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (smp_tmo) begin
                    go_fail = 1'b1;
                end else if (smp_vld) begin
                    vote_d  = smp_vote;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                // Code 0 only establishes the reference phase; the flip is searched from code 1 up.
                if (code_q == '0) begin
                    ref_d   = vote_q;
                    code_d  = code_inc(code_q);
                    state_d = ST_SETTLE;
                end else if (vote_q != ref_q) begin
                    state_d  = ST_DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    locked_d = 1'b1;
                    dis_d    = LOCK_DIS;
                end else if (code_q != DLY_CODE_MAX) begin
                    code_d  = code_inc(code_q);
                    state_d = ST_SETTLE;
                end else begin
                    go_fail = 1'b1;
                end
            end
            ST_DONE: begin
                launch = start;
`ifdef CYCLONEII_DLY_CAL_SEQ_TRACK_EN
                if (!start) begin
                    if (trk_cnt_q == TCW'(TRACK_INTERVAL - 1)) begin
                        state_d    = ST_TRACK;
                        trk_step_d = TRK_CUR;
                    end else begin
                        trk_cnt_d = trk_cnt_q + 1'b1;
                    end
                end
`endif
            end
`ifdef CYCLONEII_DLY_CAL_SEQ_TRACK_EN
            ST_TRACK: begin
                case (trk_step_q)
                    TRK_CUR: begin
                        if (smp_tmo) begin
                            go_fail = 1'b1;
                        end else if (smp_vld) begin
                            if (smp_vote == ref_q) begin
                                code_d  = code_inc(code_q);
                                state_d = ST_DONE;
                            end else if (code_q == '0) begin
                                state_d = ST_DONE;
                            end else begin
                                trk_home_d = code_q;
                                code_d     = code_q - 1'b1;
                                trk_step_d = TRK_SETTLE;
                            end
                        end
                    end
                    TRK_SETTLE: begin
                        if (settle_last) begin
                            settle_d   = '0;
                            trk_step_d = TRK_LOW;
                        end else begin
                            settle_d = settle_q + 1'b1;
                        end
                    end
                    default: begin
                        // Probe one code below: keep it only if it already shows the flipped phase.
                        if (smp_tmo) begin
                            go_fail = 1'b1;
                        end else if (smp_vld) begin
                            if (smp_vote == ref_q) code_d = trk_home_q;
                            state_d = ST_DONE;
                        end
                    end
                endcase
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (launch) begin
            state_d  = ST_SETTLE;
            code_d   = '0;
            settle_d = '0;
            dis_d    = 1'b0;
            busy_d   = 1'b1;
            done_d   = 1'b0;
            locked_d = 1'b0;
            error_d  = 1'b0;
        end
        if (go_fail) begin
            state_d  = ST_FAIL;
            code_d   = '0;
            settle_d = '0;
            dis_d    = 1'b1;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            locked_d = 1'b0;
            error_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge devclrn) begin
        if (!devclrn) begin
            state_q  <= ST_IDLE;
            code_q   <= '0;
            ref_q    <= 1'b0;
            vote_q   <= 1'b0;
            settle_q <= '0;
            dis_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            locked_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            ref_q    <= ref_d;
            vote_q   <= vote_d;
            settle_q <= settle_d;
            dis_q    <= dis_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            locked_q <= locked_d;
            error_q  <= error_d;
        end
    end

`ifdef CYCLONEII_DLY_CAL_SEQ_TRACK_EN
    always_ff @(posedge clk or negedge devclrn) begin
        if (!devclrn) begin
            trk_step_q <= TRK_CUR;
            trk_cnt_q  <= '0;
            trk_home_q <= '0;
        end else begin
            trk_step_q <= trk_step_d;
            trk_cnt_q  <= trk_cnt_d;
            trk_home_q <= trk_home_d;
        end
    end
`endif

    assign delayctrlout       = code_q;
    assign disablecalibration = dis_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign locked             = locked_q;
    assign error              = error_q;

endmodule

// File: tb/tb_cycloneii_dly_cal_sequencer.sv
// Bench: jittered atom model with a phase flip at a chosen code, a per-cycle rule checker and directed end results.
module tb_cycloneii_dly_cal_sequencer;

    localparam int NS = 15;
    localparam int SC = 32;
    localparam int TC = 4096;
    localparam int TI = 65536;
    localparam int BUDGET = 15000;

    logic       clk = 1'b0;
    logic       devclrn = 1'b0;
    logic       start = 1'b0;
    logic       caldata = 1'b0;
    logic       dlyclk = 1'b0;
    logic [5:0] code;
    logic       dis, busy, done, locked, error;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   flip = 64;       // first code whose sampled phase differs from code 0; 64 = never
    int   exp_lock = 64;   // code the checker expects while locked
    logic base = 1'b0;
    bit   atom_dead = 1'b0;
    bit   mon_en = 1'b0;
    int   ev_idx = 0;

    cycloneii_dly_cal_sequencer #(
        .NUM_SAMPLES   (NS),
        .SETTLE_CYCLES (SC),
        .TIMEOUT_CYCLES(TC),
        .TRACK_INTERVAL(TI),
        .lpm_type      ("cycloneii_dly_cal_sequencer")
    ) dut (
        .clk                      (clk),
        .devclrn                  (devclrn),
        .start                    (start),
        .calibratedata            (caldata),
        .pllcalibrateclkdelayedout(dlyclk),
        .delayctrlout             (code),
        .disablecalibration       (dis),
        .busy                     (busy),
        .done                     (done),
        .locked                   (locked),
        .error                    (error)
    );

    always #10 clk = ~clk;

    // Atom: delayed clock of 5..9 clk periods; data changes only at its rising edge, at most 1 wrong bit in 3.
    initial begin
        #3;
        forever begin
            #(10 * $urandom_range(5, 9));
            if (atom_dead) begin
                dlyclk = 1'b0;
            end else if (!dlyclk) begin
                ev_idx++;
                caldata = ((int'(code) >= flip) ? ~base : base) ^
                          ((ev_idx % 3 == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
                dlyclk = 1'b1;
            end else begin
                dlyclk = 1'b0;
            end
        end
    end

    task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", what, act, exp);
        end
    endtask

    // {code, disablecalibration, busy, done, locked, error}
    function automatic logic [10:0] outs();
        return {code, dis, busy, done, locked, error};
    endfunction

    localparam logic [4:0] F_RESET = 5'b10000;
    localparam logic [4:0] F_BUSY  = 5'b01000;
    localparam logic [4:0] F_LOCK  = 5'b10110;
    localparam logic [4:0] F_FAIL  = 5'b10101;

    // Rules that must hold on every cycle, independent of how the search is sequenced.
    logic [5:0] prev_code = '0;
    logic       prev_busy = 1'b0;
    always @(negedge clk) begin
        if (mon_en && devclrn) begin
            if (busy) chk("busy_flags", {dis, done, locked, error}, 0);
            if (done) chk("done_flags", {busy, dis, locked ^ error}, 3'b011);
            if (error) chk("fail_code", code, 0);
            if (locked) chk("lock_code", code, exp_lock);
            if (busy && prev_busy && code != prev_code) begin
                chk("code_step", code, prev_code + 1);
                chk("code_limit", (int'(code) <= ((exp_lock < 64) ? exp_lock : 63)), 1);
            end
        end
        prev_code = code;
        prev_busy = busy;
    end

    task automatic do_start(input int f);
        flip = f;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        exp_lock = f;
        chk("start_response", outs(), {6'd0, F_BUSY});
    endtask

    task automatic wait_done(input string what);
        bit seen = 1'b0;
        for (int i = 0; i < BUDGET && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        chk({what, "_done_within_budget"}, seen, 1);
    endtask

    task automatic expect_lock(input string what, input logic [5:0] c);
        wait_done(what);
        chk({what, "_final"}, outs(), {c, F_LOCK});
    endtask

    initial begin
        #25 chk("reset_values", outs(), {6'd0, F_RESET});
        #20 devclrn = 1'b1;
        mon_en = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_after_reset", outs(), {6'd0, F_RESET});

        base = 1'b0;
        do_start(17);
        expect_lock("flip17", 6'd17);

        do_start(64);
        wait_done("no_flip");
        chk("no_flip_final", outs(), {6'd0, F_FAIL});

        base = 1'b1;
        do_start(63);
        expect_lock("flip63", 6'd63);

        do_start(1);
        expect_lock("flip1", 6'd1);

        // Dead delayed clock: FAIL exactly SETTLE + TIMEOUT edges after the start edge.
        atom_dead = 1'b1;
        repeat (20) @(posedge clk);
        do_start(64);
        repeat (SC + TC - 1) @(posedge clk);
        #1 chk("timeout_not_early", {busy, error}, 2'b10);
        @(posedge clk);
        #1 chk("timeout_exact", outs(), {6'd0, F_FAIL});
        atom_dead = 1'b0;

        // Asynchronous reset in the middle of sampling code 9.
        base = 1'b0;
        do_start(17);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < BUDGET && !seen; i++) begin
                @(negedge clk);
                seen = (code == 6'd9);
            end
            chk("reached_code9", seen, 1);
        end
        repeat (SC + 20) @(negedge clk);
        #3 devclrn = 1'b0;
        #1 chk("reset_mid_sample", outs(), {6'd0, F_RESET});
        #5 devclrn = 1'b1;
        do_start(17);
        expect_lock("restart_after_reset", 6'd17);

        // start pulses while busy must not disturb the search.
        base = 1'b1;
        do_start(23);
        for (int p = 0; p < 4; p++) begin
            repeat ($urandom_range(150, 400)) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            chk("busy_start_ignored", busy, 1);
        end
        expect_lock("busy_start", 6'd23);

        for (int t = 0; t < 3; t++) begin
            int f;
            f = $urandom_range(2, 30);
            base = 1'($urandom_range(0, 1));
            do_start(f);
            expect_lock("random_flip", 6'(f));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got simulation still running, expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cycloneii_dly_cal_sequencer.md
# cycloneii_dly_cal_sequencer

Calibration sequencer driving the clock delay calibration control atom from the opposite side. It consumes the divided calibration data clock (`calibratedata`) and the delayed divided calibration clock (`pllcalibrateclkdelayedout`), sweeps the 6-bit delay code, and stops at the first code where the sampled phase flips. It owns `delayctrlin` and `disablecalibration` of the atom and reports done/locked/error to the PLL control logic.

## Interface
- `NUM_SAMPLES`, 15: samples per code vote; odd, 1..255.
- `SETTLE_CYCLES`, 32: clk cycles waited after each code change; ≥1.
- `TIMEOUT_CYCLES`, 4096: max clk cycles between delayed-clock edges in SAMPLE.
- `TRACK_INTERVAL`, 65536: clk cycles between tracking checks; used only with the tracking macro.
- `lpm_type`, "cycloneii_dly_cal_sequencer".
- `clk`  in  1  system clock; ≥4× the `pllcalibrateclkdelayedout` frequency.
- `devclrn`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle request to (re)calibrate.
- `calibratedata`  in  1  divided data clock from the atom; asynchronous.
- `pllcalibrateclkdelayedout`  in  1  delayed divided cal clock from the atom; asynchronous.
- `delayctrlout`  out  6  delay code to atom `delayctrlin`.
- `disablecalibration`  out  1  high holds atom dividers in reset.
- `busy`  out  1  search in progress.
- `done`  out  1  search finished, success or fail; sticky until next start.
- `locked`  out  1  edge found; `delayctrlout` valid.
- `error`  out  1  no edge found or delayed clock dead.

## Operation
- Reset values: `delayctrlout`=0, `disablecalibration`=1, `busy`=0, `done`=0, `locked`=0, `error`=0; state IDLE.
- Both async inputs pass through 2-flop synchronizers of equal depth. A sample event is a synchronized 0→1 of the delayed clock; the synchronized `calibratedata` level is taken in that same cycle.
- Vote: count ones over `NUM_SAMPLES` events; vote=1 iff ones > NUM_SAMPLES/2.
- States:
  - IDLE/DONE/FAIL: `start`=1 → code=0, clear done/locked/error, `disablecalibration`=0, `busy`=1, go to SETTLE.
  - SETTLE: count `SETTLE_CYCLES`, then go to SAMPLE with counters cleared.
  - SAMPLE: collect votes. No event for `TIMEOUT_CYCLES` → FAIL.
  - EVAL, one cycle. At code 0, store vote as `ref_vote`, then code+1 → SETTLE. At code>0, vote≠`ref_vote` → DONE with `locked`=1 and code held. Otherwise code<63 → code+1 → SETTLE; code=63 → FAIL.
- DONE: `busy`=0, `done`=1, `disablecalibration`=1 (without tracking).
- FAIL: `busy`=0, `done`=1, `error`=1, `delayctrlout`=0, `disablecalibration`=1.
- `start` while `busy` is ignored. `devclrn` low in any state forces reset values immediately.
- Code increments saturate at 63 and never wrap.

## Timing
- `start` seen at edge N → `busy`=1, `disablecalibration`=0 after edge N; SETTLE runs from N+1.
- The new code is driven in the EVAL cycle. The SETTLE count starts on the following cycle.
- Per-code time = `SETTLE_CYCLES` + sampling time + 1 cycle EVAL.
- `done`, `locked` and `error` all rise on the same edge in which the state enters DONE or FAIL.
- A timeout counter hitting `TIMEOUT_CYCLES` and a sample event in the same cycle: the event wins and the counter clears.

## Configuration
- `CYCLONEII_DLY_CAL_SEQ_TRACK_EN` defined:
  - In DONE, `disablecalibration` stays 0.
  - Every `TRACK_INTERVAL` cycles, take a vote at the current code.
  - If that vote = `ref_vote`, code+1, saturating at 63.
  - Otherwise take a vote at code−1. If that vote ≠ `ref_vote`, code−1, saturating at 0.
  - `locked` stays 1. A tracking timeout → FAIL.
- Undefined: DONE is static and no tracking logic is built.

## Structure
- Package `cycloneii_dly_cal_pkg`: state enum (IDLE, SETTLE, SAMPLE, EVAL, DONE, FAIL, plus TRACK with the macro), `DLY_CODE_W`=6, `DLY_CODE_MAX`=63.
- Sub-module `cycloneii_dly_cal_phase_sampler`: synchronizers, edge detect, sample counter, vote and timeout flag. The sequencer FSM, code register and flags live in the top.

## Test plan
- Atom model with phase flip at code 17, NUM_SAMPLES=15 → `done`=1, `locked`=1, `delayctrlout`=17, `error`=0, `disablecalibration`=1.
- Flip never occurs → FAIL after code 63 is evaluated: `error`=1, `delayctrlout`=0, `locked`=0.
- Delayed clock held 0 after `start` → `error`=1 exactly `TIMEOUT_CYCLES` after SAMPLE entry.
- `devclrn` pulsed low mid-SAMPLE at code 9 → all outputs at reset values the same cycle. A new `start` restarts the search at code 0.
- `start` pulsed while `busy` → no restart; final result identical to the undisturbed run.
- With TRACK_EN: lock at 17, then the model flip moves to 18 → code becomes 18 within one `TRACK_INTERVAL`; the flip moves back to 17 → code returns to 17.
